// File: rtl/logic_pkg.sv
// -----------------------------------------------------------------------------
// logic_pkg
//   Shared definitions for the pipelined bitwise logic unit.
//   - op_e : 3-bit operation select. All eight encodings are defined, so no
//            illegal-op handling is needed anywhere downstream.
//   - OP_W : width of the operation select field.
// -----------------------------------------------------------------------------
package logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,   // a & ~b
    OP_PASSA = 3'd7
  } op_e;

endpackage : logic_pkg

// File: rtl/logic_op_core.sv
// -----------------------------------------------------------------------------
// logic_op_core
//   Purely combinational bitwise operator, WIDTH bits wide. There is no carry
//   chain and no sign/zero extension: every result bit depends only on the
//   operand bits in the same position.
//
// Ports
//   a   in  WIDTH  operand A
//   b   in  WIDTH  operand B
//   op  in  op_e   operation select
//   y   out WIDTH  result
// -----------------------------------------------------------------------------
module logic_op_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDN:  y = a & ~b;
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end

endmodule : logic_op_core

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Two-stage pipelined bitwise logic unit with valid/ready handshakes on both
//   sides. One operation per cycle when the consumer is ready; stalls without
//   loss or duplication under backpressure.
//
//   S1 holds the accepted operands and op. S2 holds the computed result and
//   its zero/negative flags, so the output pins are driven straight from
//   flops.
//
// Parameters
//   WIDTH  operand/result width (2..64)
//   CNT_W  width of the delivered-result counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands/op presented
//   in_ready   out  input accepted this cycle
//   in_a       in   operand A
//   in_b       in   operand B
//   in_op      in   operation select (logic_pkg::op_e encoding)
//   out_valid  out  result available
//   out_ready  in   consumer accepts result
//   out_y      out  result
//   out_zero   out  out_y == 0
//   out_neg    out  out_y MSB
//   op_count   out  number of results delivered (wraps)
// -----------------------------------------------------------------------------
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] op_count
);

  function automatic logic flag_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  function automatic logic flag_neg(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  op_e              s1_op_q,    s1_op_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q,        y_d;
  logic             zero_q,     zero_d;
  logic             neg_q,      neg_d;

  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic             adv1;
  logic             adv2;
  logic             out_fire;
  logic [WIDTH-1:0] core_y;

  // A stage may load whenever it is empty or its current content leaves on
  // this edge. in_ready must not look at in_valid, otherwise a producer that
  // waits for in_ready before raising in_valid would deadlock.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign out_fire = s2_valid_q && out_ready;

  // ---- Input handshake -> S1 ----
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = in_a;
        s1_b_d  = in_b;
        s1_op_d = op_e'(in_op);
      end
    end
  end

  // ---- S1 -> operator -> S2 ----
  logic_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (s1_a_q),
    .b  (s1_b_q),
    .op (s1_op_q),
    .y  (core_y)
  );

  // Flags are derived from the same value that is loaded into y_q, so they
  // always match the registered result. When S1 is empty, y/flags keep their
  // last value; only s2_valid drops (bubble).
  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d    = core_y;
        zero_d = flag_zero(core_y);
        neg_d  = flag_neg(core_y);
      end
    end
  end

  // ---- S2 -> output handshake ----
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Control and output state: cleared by reset so nothing in flight survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
    end
  end

  // S1 operands are only meaningful while s1_valid_q is set, so they carry
  // no reset.
  always_ff @(posedge clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_op_q <= s1_op_d;
  end

  assign out_valid = s2_valid_q;
  assign out_y     = y_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign op_count  = cnt_q;

endmodule : logic_unit_pipe

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational AND block.
- Performs one of eight bitwise operations on two WIDTH-bit operands and returns the result with zero/negative flags.
- Two register stages with a valid/ready handshake on both sides, for the datapath between operand fetch and writeback.
- Sustains one operation per cycle; stalls cleanly under backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits (legal range 2..64).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts the input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  operation select (logic_pkg::op_e).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result.
- out_zero  out  1  out_y == 0.
- out_neg  out  1  out_y[WIDTH-1].
- op_count  out  CNT_W  number of results delivered.

Behaviour:
- Reset (asynchronous, active-high, any time): s1_valid=0, s2_valid=0, out_y=0, out_zero=0, out_neg=0, op_count=0. in_ready is 1 on the first cycle after release. In-flight operations are discarded, never delivered.
- Ops by in_op value: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A.
  - All ops are purely bitwise at WIDTH bits; there is no carry and no extension.
- Stage 1 (S1) registers a, b and op on an input handshake (in_valid && in_ready).
- Stage 2 (S2) computes the result from the S1 registers and registers y, zero and neg.
  - Flags are computed from the registered y value. No flag logic sits on the output path.
- Advance rules:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational; no dependency on in_valid).
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+1, provided out_ready stayed high.
- Throughput: 1 result per cycle while out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, out_y/out_zero/out_neg/out_valid hold stable.
  - S1 fills if empty; once S1 is also full, in_ready=0.
  - No data is lost or duplicated.
- Bubbles: if S1 is empty and adv2 holds, s2_valid clears on the next edge. out_y keeps its last value; it is don't-care while out_valid=0.
- Simultaneous events: out_ready=1 with a full pipeline and in_valid=1 lets S2 take S1 and S1 take the new input on the same edge.
- op_count increments on each output handshake (out_valid && out_ready) and wraps modulo 2^CNT_W.
- Illegal in_op values cannot occur (3 bits, all 8 encodings defined).
- Handshake rule: once in_valid is asserted, the producer holds in_a/in_b/in_op stable until accepted.

Decomposition:
- logic_pkg:
  - op_e enum (3-bit): OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN, OP_PASSA.
  - OP_W = 3 constant.
- Sub-module logic_op_core: purely combinational, parametrised WIDTH; inputs a, b, op; output y. Instantiated once between S1 and S2.
- The top level holds the two pipeline stages, the handshake logic and the counter.

Test Plan:
- Reset release, then OP_AND with a=3, b=3, out_ready=1 → out_y=3, zero=0, neg=0 two edges after accept; op_count=1.
- Back-to-back stream, one per cycle: AND 21&9, AND 8&1, AND 0&0, OR 8|1, XOR 0xFFFF^0x00FF → results 1, 0 (zero=1), 0 (zero=1), 9, 0xFF00 (neg=1) on consecutive cycles; op_count=5.
- Backpressure: out_ready=0 for 4 cycles while 3 inputs are offered.
  - Required: in_ready drops after 2 accepts, out_y holds stable, third input waits.
  - After out_ready=1: all 3 results in order, no gaps.
- All 8 ops with a=0xA5A5, b=0x0F0F → 0x0505, 0xAFAF, 0xAAAA, 0xFAFA, 0x5050, 0x5555, 0xA0A0, 0xA5A5.
- Reset mid-operation: assert rst asynchronously (between edges) with both stages full.
  - Required: out_valid=0 and op_count=0 immediately.
  - After release: no stale result appears; the next input gives the correct result.
- WIDTH=8, CNT_W=4: 17 NAND ops with a=0x00, b=0x00 → each out_y=0xFF, neg=1; op_count wraps to 1.
